// File: rtl/dstep_pkg.sv
// Shared types and helpers for the decade-counter step scheduler.
// States, decade size and position-to-onehot decode.
package dstep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    CHECK,
    DONE
  } state_t;

  localparam int DECADE = 10;
  localparam int PW     = 4;

  function automatic logic [DECADE-1:0] pos_onehot_of(
    input logic [PW-1:0] p
  );
    logic [DECADE-1:0] v;
    v = '0;
    for (int i = 0; i < DECADE; i++)
      if (p == PW'(i)) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decade_pos_tracker.sv
// Shadow copy of the external decade counter position and
// comparison against the counter's Q0-Q9 and carry outputs.
module decade_pos_tracker
  import dstep_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [DECADE-1:0] pos_onehot,
  input  logic              carry_in,
  output logic [PW-1:0]     shadow,
  output logic              match
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      shadow <= '0;
    else if (clear)
      shadow <= '0;
    else if (advance)
      shadow <= (shadow == PW'(DECADE-1)) ? '0 : shadow + PW'(1);
  end

  // Counter carry-out is high for the lower half of the decade.
  assign match = (pos_onehot == pos_onehot_of(shadow))
              && (carry_in == (shadow < PW'(5)));

endmodule

// File: rtl/decade_step_sched.sv
// Arbitrates step requests and drives a decade counter one position per step.
// Define STEP_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module decade_step_sched
  import dstep_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int SW   = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*SW-1:0] req_steps,
  input  logic              home,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              err,
  output logic              cnt_en_n,
  output logic              cnt_rst,
  input  logic [DECADE-1:0] pos_onehot,
  input  logic              carry_in
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic          found;
  logic [SW-1:0] rem;
  logic [SW-1:0] pick_steps;
  logic [PW-1:0] shadow;
  logic          match;
  logic          idle;

`ifdef STEP_SCHED_RR_EN
  logic [IW-1:0] last;
`endif

  assign idle = (state == IDLE);
  assign busy = !idle;

  // Descending scan so the first candidate in search order wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
`ifdef STEP_SCHED_RR_EN
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % NREQ);
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
`endif
  end

  assign pick_steps = req_steps[int'(pick)*SW +: SW];

  decade_pos_tracker u_trk (
    .clk        (clk),
    .reset      (reset),
    .clear      (idle && home),
    .advance    (state == STEP),
    .pos_onehot (pos_onehot),
    .carry_in   (carry_in),
    .shadow     (shadow),
    .match      (match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      win      <= '0;
      rem      <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      cnt_en_n <= 1'b1;
      cnt_rst  <= 1'b0;
`ifdef STEP_SCHED_RR_EN
      last     <= IW'(NREQ - 1);
`endif
    end else begin
      gnt      <= '0;
      done     <= '0;
      cnt_en_n <= 1'b1;
      cnt_rst  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (home) begin
            cnt_rst <= 1'b1;
            err     <= 1'b0;
          end else if (found) begin
            gnt <= NREQ'(1) << pick;
            win <= pick;
            rem <= pick_steps;
`ifdef STEP_SCHED_RR_EN
            last <= pick;
`endif
            if (pick_steps != '0) begin
              state    <= STEP;
              cnt_en_n <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
        end
        STEP: begin
          rem   <= rem - SW'(1);
          state <= CHECK;
        end
        CHECK: begin
          if (!match) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (rem != '0) begin
            state    <= STEP;
            cnt_en_n <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= NREQ'(1) << win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = ^shadow;

endmodule

// File: tb/tb_decade_step_sched.sv
// Self-checking bench for decade_step_sched with a behavioural
// decade counter and optional fault injection on its outputs.
module tb_decade_step_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] req_steps;
  logic       home;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       err;
  logic       cnt_en_n;
  logic       cnt_rst;
  logic [9:0] pos_onehot;
  logic       carry_in;
  logic       bad = 1'b0;
  int         tpos = 0;

  int n_chk = 0;
  int n_fail = 0;
  int model_pos = 0;

  typedef struct {
    logic [1:0] m;
    logic [3:0] s0;
    logic [3:0] s1;
    int         eidx;
  } vec_t;

  typedef struct {
    int idx;
    int n;
    int pos;
  } exp_t;

  vec_t tbl[6];
  exp_t sbq[$];

  decade_step_sched #(.NREQ(2), .SW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_steps  (req_steps),
    .home       (home),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .err        (err),
    .cnt_en_n   (cnt_en_n),
    .cnt_rst    (cnt_rst),
    .pos_onehot (pos_onehot),
    .carry_in   (carry_in)
  );

  always #5 clk = ~clk;

  // Behavioural decade counter
  always @(posedge clk or posedge reset) begin
    if (reset) tpos <= 0;
    else if (cnt_rst) tpos <= 0;
    else if (!cnt_en_n) tpos <= (tpos == 9) ? 0 : tpos + 1;
  end

  assign pos_onehot = bad ? 10'h000 : (10'd1 << tpos);
  assign carry_in   = (tpos < 5);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (gnt != 2'b00) ok = 1'b1;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic run_req(input logic [1:0] m, input logic [3:0] s0,
                         input logic [3:0] s1, input int eidx,
                         input bit eerr);
    exp_t e;
    bit   ok;
    int   lat;
    int   lows;
    e.idx = eidx;
    e.n   = (eidx == 0) ? int'(s0) : int'(s1);
    e.pos = (model_pos + e.n) % 10;
    sbq.push_back(e);
    req_steps = {s1, s0};
    req = m;
    wait_gnt(ok);
    if (ok) begin
      e = sbq.pop_front();
      chk("gnt_idx", 32'(gnt), 32'(1 << e.idx));
      req  = 2'b00;
      lat  = 0;
      lows = (cnt_en_n == 1'b0) ? 1 : 0;
      ok   = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
        tick();
        lat++;
        if (!cnt_en_n) lows++;
        if (done != 2'b00) ok = 1'b1;
      end
      if (!ok) begin
        chk("done_timeout", 0, 1);
      end else begin
        chk("done_latency", lat, 2 * e.n + 1);
        chk("done_idx", 32'(done), 32'(1 << e.idx));
        chk("step_pulses", lows, e.n);
        chk("counter_pos", tpos, e.pos);
        chk("err", 32'(err), 32'(eerr));
      end
      model_pos = e.pos;
    end else begin
      void'(sbq.pop_front());
      req = 2'b00;
    end
  endtask

  initial begin
    int  gq[$];
    int  ngot;
    int  lows;
    int  seen;
    bit  ok;

    tbl[0] = '{2'b01, 4'd3, 4'd0, 0};
    tbl[1] = '{2'b01, 4'd5, 4'd0, 0};
    tbl[2] = '{2'b10, 4'd0, 4'd4, 1};
    tbl[3] = '{2'b01, 4'd0, 4'd0, 0};
`ifdef STEP_SCHED_RR_EN
    tbl[4] = '{2'b11, 4'd2, 4'd7, 1};
`else
    tbl[4] = '{2'b11, 4'd2, 4'd7, 0};
`endif
    tbl[5] = '{2'b10, 4'd0, 4'd9, 1};

    reset = 1'b1;
    req = 2'b00;
    req_steps = 8'h00;
    home = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt_en_n", 32'(cnt_en_n), 1);
    chk("rst_cnt_rst", 32'(cnt_rst), 0);
    reset = 1'b0;
    tick();

    home = 1'b1;
    tick();
    chk("home_cnt_rst", 32'(cnt_rst), 1);
    home = 1'b0;
    tick();
    chk("home_cnt_rst_end", 32'(cnt_rst), 0);

    for (int i = 0; i < 6; i++)
      run_req(tbl[i].m, tbl[i].s0, tbl[i].s1, tbl[i].eidx, 1'b0);

    // Held double request, re-arbitrated after each done
`ifdef STEP_SCHED_RR_EN
    gq = '{0, 1, 0};
`else
    gq = '{0, 0, 0};
`endif
    req_steps = {4'd1, 4'd1};
    req = 2'b11;
    ngot = 0;
    for (int c = 0; c < 60 && ngot < 3; c++) begin
      tick();
      if (gnt != 2'b00) begin
        ngot++;
        chk("held_gnt", 32'(gnt), 32'(1 << gq.pop_front()));
        if (ngot == 3) req = 2'b00;
      end
    end
    chk("held_count", ngot, 3);
    repeat (5) tick();
    model_pos = (model_pos + 3) % 10;
    chk("held_pos", tpos, model_pos);
    chk("held_idle", 32'(busy), 0);

    // Mismatch injected on the second check of a 5-step move
    req_steps = {4'd0, 4'd5};
    req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    lows = 1;
    for (int c = 0; c < 10 && lows < 2; c++) begin
      tick();
      if (!cnt_en_n) lows++;
    end
    chk("fault_step2", lows, 2);
    bad = 1'b1;
    tick();
    tick();
    bad = 1'b0;
    chk("fault_err", 32'(err), 1);
    chk("fault_idle", 32'(busy), 0);
    seen = (done != 2'b00) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done != 2'b00) seen++;
    end
    chk("fault_no_done", seen, 0);
    model_pos = (model_pos + 2) % 10;

    run_req(2'b01, 4'd0, 4'd0, 0, 1'b1);

    home = 1'b1;
    tick();
    home = 1'b0;
    chk("home2_cnt_rst", 32'(cnt_rst), 1);
    chk("home2_err", 32'(err), 0);
    tick();
    chk("home2_pos", tpos, 0);
    model_pos = 0;

    // Reset in the middle of a move
    req_steps = {4'd0, 4'd6};
    req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    lows = 1;
    for (int c = 0; c < 10 && lows < 2; c++) begin
      tick();
      if (!cnt_en_n) lows++;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_cnt_en_n", 32'(cnt_en_n), 1);
    chk("mid_rst_cnt_rst", 32'(cnt_rst), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done != 2'b00) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    model_pos = 0;
    run_req(2'b01, 4'd1, 4'd0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
